// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/8-data/even-parity/stop frames into a CPU read buffer.
// A synchronised copy of rxd drives a phase-counted FSM; completed bytes load d_out and the status flags.
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_EN   = 1'b1
) (
  input  logic       clk16x,
  input  logic       clr,
  input  logic       rxd,
  input  logic       rdn,
  output logic [7:0] d_out,
  output logic       r_ready,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_N-1:0]  sync_q;
  logic               rxs;
  logic [3:0]         phase_q, phase_d;
  logic [2:0]         bit_q, bit_d;
  logic               stop_done_q, stop_done_d;
  logic [7:0]         shift_q, shift_d;
  logic               perr_q, perr_d;
  logic               stop_ok_q, stop_ok_d;
  logic               load;
  logic [7:0]         dout_q, dout_d;
  logic               rdy_q, rdy_d;
  logic               pe_q, pe_d;
  logic               fe_q, fe_d;
  logic               ov_q, ov_d;

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], rxd};
    end
  end

  assign rxs = sync_q[SYNC_N-1];

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      phase_q     <= 4'd0;
      bit_q       <= 3'd0;
      stop_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      stop_done_q <= stop_done_d;
    end
  end

  // Frame datapath is only meaningful between start detection and load, so it carries no reset.
  always_ff @(posedge clk16x) begin
    shift_q   <= shift_d;
    perr_q    <= perr_d;
    stop_ok_q <= stop_ok_d;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + 4'd1;
    bit_d       = bit_q;
    stop_done_d = stop_done_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    stop_ok_d   = stop_ok_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = 4'd0;
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (phase_q == 4'd7) begin
          phase_d = 4'd0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d     = DATA;
            bit_d       = 3'd0;
            perr_d      = 1'b0;
            stop_done_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (phase_q == 4'd15) begin
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
            end
          end
        end
      end
      PARITY: begin
        if (phase_q == 4'd15) begin
          perr_d  = rxs ^ (^shift_q);
          state_d = STOP;
        end
      end
      STOP: begin
        // Sample mid stop bit, then commit the byte on the following edge.
        if (stop_done_q) begin
          load        = 1'b1;
          stop_done_d = 1'b0;
          phase_d     = 4'd0;
          if (stop_ok_q) begin
            state_d = IDLE;
          end else begin
            state_d = BREAK;
          end
        end else if (phase_q == 4'd15) begin
          stop_ok_d   = rxs;
          stop_done_d = 1'b1;
        end
      end
      BREAK: begin
        phase_d = 4'd0;
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    rdy_d  = rdy_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    ov_d   = ov_q;
    if (!rdn) begin
      rdy_d = 1'b0;
      pe_d  = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
    end
    // A byte load takes priority over a read strobe on the same edge.
    if (load) begin
      dout_d = shift_q;
      rdy_d  = 1'b1;
      pe_d   = perr_q & PARITY_EN;
      fe_d   = ~stop_ok_q;
      ov_d   = rdy_q & rdn;
    end
  end

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      dout_q <= 8'h00;
      rdy_q  <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      rdy_q  <= rdy_d;
      pe_q   <= pe_d;
      fe_q   <= fe_d;
      ov_q   <= ov_d;
    end
  end

  assign d_out        = dout_q;
  assign r_ready      = rdy_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign overrun      = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on rxd and outputs are checked on negedges.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk16x = 1'b0;
  logic       clr;
  logic       rxd;
  logic       rdn;
  logic [7:0] d_out;
  logic       r_ready;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  int         rise_cnt = 0;
  logic       rdy_prev = 1'b0;
  logic [7:0] cap_d = 8'h00;
  logic       cap_pe = 1'b0;
  logic       cap_fe = 1'b0;

  uart_rx #(.SYNC_STAGES(2), .PARITY_EN(1'b1)) dut (
    .clk16x      (clk16x),
    .clr         (clr),
    .rxd         (rxd),
    .rdn         (rdn),
    .d_out       (d_out),
    .r_ready     (r_ready),
    .parity_error(parity_error),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk16x = ~clk16x;

  // Records each rising edge of r_ready together with the byte and flags loaded with it.
  always @(negedge clk16x) begin
    if (r_ready === 1'b1 && rdy_prev !== 1'b1) begin
      rise_cnt = rise_cnt + 1;
      cap_d    = d_out;
      cap_pe   = parity_error;
      cap_fe   = frame_error;
    end
    rdy_prev = r_ready;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk16x);
  endtask

  // Bit k lasts pa cycles for even k and pb cycles for odd k.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int pa, input int pb);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rxd = f[k];
      repeat (((k % 2) == 0) ? pa : pb) @(negedge clk16x);
    end
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ^d, 1'b1, 16, 16);
  endtask

  task automatic read_pulse();
    rdn = 1'b0;
    @(negedge clk16x);
    rdn = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    rxd = 1'b1;
    rdn = 1'b1;
    idle(3);
    checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", d_out); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", overrun); end
    clr = 1'b0;
    idle(4);
  endtask

  task automatic test_reset_midframe();
    logic [10:0] f;
    send_byte(8'h3C);
    checks++; if (d_out !== 8'h3C) begin errors++; $display("FAIL pre_dout: got %h want 3c", d_out); end
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL pre_rdy: got %b want 1", r_ready); end
    f = {1'b1, 1'b0, 8'h5A, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rxd = f[k];
      idle(16);
    end
    clr = 1'b1;
    rxd = 1'b1;
    idle(2);
    checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL mid_clr_dout: got %h want 00", d_out); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL mid_clr_rdy: got %b want 0", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL mid_clr_pe: got %b want 0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL mid_clr_fe: got %b want 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_clr_ov: got %b want 0", overrun); end
    clr = 1'b0;
    idle(20);
    send_byte(8'hA5);
    checks++; if (d_out !== 8'hA5) begin errors++; $display("FAIL a5_dout: got %h want a5", d_out); end
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL a5_rdy: got %b want 1", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL a5_pe: got %b want 0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL a5_fe: got %b want 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL a5_ov: got %b want 0", overrun); end
    read_pulse();
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL a5_read_rdy: got %b want 0", r_ready); end
  endtask

  task automatic test_parity();
    send_byte(8'h37);
    checks++; if (d_out !== 8'h37) begin errors++; $display("FAIL par_ok_dout: got %h want 37", d_out); end
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL par_ok_rdy: got %b want 1", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL par_ok_pe: got %b want 0", parity_error); end
    read_pulse();
    send_frame(8'h37, 1'b0, 1'b1, 16, 16);
    checks++; if (d_out !== 8'h37) begin errors++; $display("FAIL par_bad_dout: got %h want 37", d_out); end
    checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL par_bad_pe: got %b want 1", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL par_bad_fe: got %b want 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL par_bad_ov: got %b want 0", overrun); end
    read_pulse();
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL par_read_rdy: got %b want 0", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL par_read_pe: got %b want 0", parity_error); end
    checks++; if (d_out !== 8'h37) begin errors++; $display("FAIL par_read_dout: got %h want 37", d_out); end
  endtask

  task automatic test_false_start();
    int n0;
    n0 = rise_cnt;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b want 0", r_ready); end
    checks++; if (rise_cnt - n0 !== 0) begin errors++; $display("FAIL glitch_loads: got %0d want 0", rise_cnt - n0); end
    send_byte(8'h00);
    checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL zero_dout: got %h want 00", d_out); end
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL zero_rdy: got %b want 1", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL zero_pe: got %b want 0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL zero_fe: got %b want 0", frame_error); end
    read_pulse();
  endtask

  task automatic test_framing();
    int n0;
    n0 = rise_cnt;
    rdn = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, 16, 16);
    rxd = 1'b0;
    idle(300);
    checks++; if (rise_cnt - n0 !== 1) begin errors++; $display("FAIL brk_loads: got %0d want 1", rise_cnt - n0); end
    checks++; if (cap_d !== 8'hFF) begin errors++; $display("FAIL brk_dout: got %h want ff", cap_d); end
    checks++; if (cap_fe !== 1'b1) begin errors++; $display("FAIL brk_fe: got %b want 1", cap_fe); end
    checks++; if (cap_pe !== 1'b0) begin errors++; $display("FAIL brk_pe: got %b want 0", cap_pe); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL brk_rdn_low_rdy: got %b want 0", r_ready); end
    rxd = 1'b1;
    idle(20);
    send_byte(8'h5A);
    idle(2);
    checks++; if (rise_cnt - n0 !== 2) begin errors++; $display("FAIL post_brk_loads: got %0d want 2", rise_cnt - n0); end
    checks++; if (cap_d !== 8'h5A) begin errors++; $display("FAIL post_brk_dout: got %h want 5a", cap_d); end
    checks++; if (cap_fe !== 1'b0) begin errors++; $display("FAIL post_brk_fe: got %b want 0", cap_fe); end
    rdn = 1'b1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    fork
      begin : sender
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
      end
      begin : reader
        int n;
        n = 0;
        while (r_ready !== 1'b1 && n < 400) begin
          @(negedge clk16x);
          n++;
        end
        checks++;
        if (r_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_first_load: r_ready=%b after %0d cycles, want 1", r_ready, n);
        end else begin
          // Frames are exactly 176 cycles apart, so the 0x22 load lands 176 edges after the 0x11 load.
          idle(175);
          rdn = 1'b0;
          @(negedge clk16x);
          rdn = 1'b1;
          checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL b2b_22_rdy: got %b want 1", r_ready); end
          checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_22_ov: got %b want 0", overrun); end
          checks++; if (d_out !== 8'h22) begin errors++; $display("FAIL b2b_22_dout: got %h want 22", d_out); end
        end
      end
    join
    checks++; if (d_out !== 8'h33) begin errors++; $display("FAIL b2b_33_dout: got %h want 33", d_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_33_ov: got %b want 1", overrun); end
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL b2b_33_rdy: got %b want 1", r_ready); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL b2b_33_fe: got %b want 0", frame_error); end
    read_pulse();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_read_ov: got %b want 0", overrun); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL b2b_read_rdy: got %b want 0", r_ready); end
  endtask

  task automatic test_tolerance();
    send_frame(8'hC3, 1'b0, 1'b1, 15, 17);
    idle(16);
    checks++; if (d_out !== 8'hC3) begin errors++; $display("FAIL tol_a_dout: got %h want c3", d_out); end
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL tol_a_rdy: got %b want 1", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL tol_a_pe: got %b want 0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL tol_a_fe: got %b want 0", frame_error); end
    read_pulse();
    idle(4);
    send_frame(8'hC3, 1'b0, 1'b1, 17, 15);
    idle(16);
    checks++; if (d_out !== 8'hC3) begin errors++; $display("FAIL tol_b_dout: got %h want c3", d_out); end
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL tol_b_rdy: got %b want 1", r_ready); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL tol_b_pe: got %b want 0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL tol_b_fe: got %b want 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL tol_b_ov: got %b want 0", overrun); end
  endtask

  initial begin
    clr = 1'b1;
    rxd = 1'b1;
    rdn = 1'b1;
    @(negedge clk16x);
    test_reset();
    test_reset_midframe();
    test_parity();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_tolerance();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
